weighted_rank_order_stream: RTL and testbench
=============================================

Name: weighted_rank_order_stream

Overview:
Streaming weighted order-statistic filter. It generalises the masked rank-order kernel in two ways: per-tap integer weights replace the 1-bit mask, and a cumulative-weight threshold replaces the rank index. It adds valid-qualified input, a window-fill tracker, flush and a fixed 2-stage pipeline. It sits in the filter kernel between the sample source and the processor's result path, with throughput of one sample per clock.

Parameters:
N, 7, window depth (taps); tap 0 = newest sample, tap N-1 = oldest.
DATA_BITS, 8, sample width, unsigned.
WEIGHT_BITS, 3, per-tap weight width, unsigned; weight 0 excludes the tap.
SUM_BITS, $clog2(N*(2**WEIGHT_BITS-1)+1), cumulative weight / threshold width (derived; do not override).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  clear window-fill state and in-flight results
in_valid  in  1  in_data is a new sample this cycle
in_data  in  DATA_BITS  new sample
weights  in  N*WEIGHT_BITS  tap weights; tap i at bits [i*WEIGHT_BITS +: WEIGHT_BITS]
thresh  in  SUM_BITS  weighted rank threshold T
out_valid  out  1  out_data valid, one-cycle pulse per result
out_data  out  DATA_BITS  weighted order statistic
out_sat  out  1  T exceeded the total window weight (qualified by out_valid)

Behaviour:
- Reset: one clock, synchronous, active-high; clk/rst as named above.
- On rst: all window registers, fill counter, stage valids, out_valid, out_data and out_sat are 0.
- Stage 0 (in_valid=1): shift the window (tap i <= tap i-1, tap 0 <= in_data). Increment fill, saturating at N. Capture weights and thresh alongside the shift.
- in_valid=0: window, fill and the captured config hold; no result is produced.
- Stage 1: for each tap i, register C_i = sum of w_j over all taps j with key_j <= key_i.
  - key = {value, index}, which gives a strict total order; ties on value are broken by the lower tap index.
  - Use SUM_BITS arithmetic with no overflow.
  - Also register the total weight W = sum of w_j.
- Stage 2:
  - out_data = minimum value among taps with C_i >= T.
  - If none qualify (T > W): out_data = maximum window value and out_sat = 1.
  - T = 0: all taps qualify, so out_data = window minimum.
  - All weights 0 with T = 0: out_data = window minimum, out_sat = 0.
  - All weights 0 with T >= 1: out_sat = 1.
- Latency: a sample accepted at edge k gives its result at edge k+2 (out_valid high for the cycle after edge k+2). Back-to-back inputs give back-to-back outputs.
- out_valid is asserted only for samples whose acceptance makes fill == N, i.e. the Nth and later samples since reset or flush.
- out_data and out_sat hold their last value while out_valid = 0.
- flush (synchronous):
  - fill <= 0 and both stage valids <= 0, so in-flight results are dropped.
  - Window contents are not cleared.
  - flush with in_valid in the same cycle: the sample is still shifted in and counts as fill = 1.
- rst mid-stream: identical to power-up; no stale out_valid afterwards.
- Config sampled at stage 0 stays bound to that result. Changing weights or thresh does not disturb results already in flight.

Decomposition:
- Shared package holds:
  - SUM_BITS derivation function.
  - Tap-index width function, $clog2(N).
  - A key-compare function (value, index) that returns "less-or-equal".
- Natural sub-module: weighted_rank_accum. It is combinational: given the window, weights and tap index i, it produces C_i. It is instantiated N times in stage 1.
- The shift register, fill counter, pipeline registers and stage-2 select tree stay in the top module.

Test Plan:
(N=5, DATA_BITS=8, WEIGHT_BITS=3)
1. Median: weights all 1, T=3; feed 10,50,20,40,30 on consecutive cycles -> the first four give no out_valid; 2 cycles after the 5th, out_valid=1, out_data=30, out_sat=0.
2. Weighted: same window (tap0=30, tap1=40, tap2=20, tap3=50, tap4=10); weights tap0=3, others 1 (W=7), T=4 -> C(10)=1, C(20)=2, C(30)=5, so out_data=30. With T=6 -> out_data=40.
3. Saturation and edge cases:
   - Weights all 1, T=6 -> out_data=50, out_sat=1.
   - T=0 -> out_data=10, out_sat=0.
   - All weights 0, T=1 -> out_sat=1.
4. Ties: window 7,7,7,3,3; weights 1, T=3 -> out_data=7. Then T=2 -> out_data=3.
5. Flush: full window streaming results; assert flush together with a valid sample -> the two in-flight results are suppressed; 4 further samples are needed before out_valid returns. Repeat with rst asserted mid-stream -> all outputs 0 and fill restarts.
6. Throughput and config binding: 20 back-to-back samples, toggling thresh every cycle -> 16 consecutive out_valid pulses, each matching a reference model that uses the thresh captured with its own sample. Gaps in in_valid give matching gaps in out_valid.

Source files
------------

// File: rtl/weighted_rank_order_stream_pkg.sv
// Shared helpers for the weighted rank-order stream filter: width derivations
// and the strict (value, tap index) key ordering used by the accumulators.
package weighted_rank_order_stream_pkg;

    // Wide enough to hold the sum of all tap weights at their maximum value.
    function automatic int calcSumBits(input int taps, input int weightBits);
        return $clog2(taps * ((1 << weightBits) - 1) + 1);
    endfunction

    function automatic int idxBits(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

    // Equal values are ordered by tap index, so every tap gets a distinct key.
    function automatic logic keyLe(input int unsigned aVal, input int aIdx,
                                   input int unsigned bVal, input int bIdx);
        return (aVal < bVal) || ((aVal == bVal) && (aIdx <= bIdx));
    endfunction

endpackage

// File: rtl/weighted_rank_order_stream_accum.sv
// Cumulative weight of one tap: the sum of the weights of every tap whose
// (value, index) key is less than or equal to the selected tap's key.
module weighted_rank_accum
    import weighted_rank_order_stream_pkg::*;
#(
    parameter int N           = 7,
    parameter int DATA_BITS   = 8,
    parameter int WEIGHT_BITS = 3,
    parameter int SUM_BITS    = calcSumBits(N, WEIGHT_BITS),
    parameter int IDX_BITS    = idxBits(N)
) (
    input  logic [N*DATA_BITS-1:0]   window_i,
    input  logic [N*WEIGHT_BITS-1:0] weights_i,
    input  logic [IDX_BITS-1:0]      tapIdx_i,
    output logic [SUM_BITS-1:0]      cSum_o
);

    logic [DATA_BITS-1:0] keyVal;

    always_comb begin
        keyVal = window_i[int'(tapIdx_i)*DATA_BITS +: DATA_BITS];
        cSum_o = '0;
        for (int j = 0; j < N; j++) begin
            if (keyLe(32'(window_i[j*DATA_BITS +: DATA_BITS]), j,
                      32'(keyVal), int'(tapIdx_i))) begin
                cSum_o = cSum_o + SUM_BITS'(weights_i[j*WEIGHT_BITS +: WEIGHT_BITS]);
            end
        end
    end

endmodule

// File: rtl/weighted_rank_order_stream.sv
// Streaming weighted order-statistic filter: window shift register, per-tap
// cumulative weights, then a select of the smallest tap reaching the threshold.
module weighted_rank_order_stream
    import weighted_rank_order_stream_pkg::*;
#(
    parameter int N           = 7,
    parameter int DATA_BITS   = 8,
    parameter int WEIGHT_BITS = 3,
    parameter int SUM_BITS    = calcSumBits(N, WEIGHT_BITS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [DATA_BITS-1:0]     in_data,
    input  logic [N*WEIGHT_BITS-1:0] weights,
    input  logic [SUM_BITS-1:0]      thresh,
    output logic                     out_valid,
    output logic [DATA_BITS-1:0]     out_data,
    output logic                     out_sat
);

    localparam int IDX_BITS  = idxBits(N);
    localparam int FILL_BITS = $clog2(N + 1);

    logic [N*DATA_BITS-1:0]   window_q,   window_d;
    logic [N*WEIGHT_BITS-1:0] weights0_q, weights0_d;
    logic [SUM_BITS-1:0]      thresh0_q,  thresh0_d;
    logic [FILL_BITS-1:0]     fill_q,     fill_d;
    logic                     s0Valid_q,  s0Valid_d;

    logic [SUM_BITS-1:0]      cSum [N];
    logic [SUM_BITS-1:0]      totalW;

    logic [N*DATA_BITS-1:0]   vals1_q;
    logic [SUM_BITS-1:0]      c1_q [N];
    logic [SUM_BITS-1:0]      total1_q;
    logic [SUM_BITS-1:0]      thresh1_q;
    logic                     s1Valid_q;

    logic [DATA_BITS-1:0]     minQual;
    logic [DATA_BITS-1:0]     maxVal;
    logic [DATA_BITS-1:0]     selData;
    logic                     selSat;

    logic                     outValid_q;
    logic [DATA_BITS-1:0]     outData_q;
    logic                     outSat_q;

    // A flush-with-sample restarts the fill count at one, not zero.
    always_comb begin
        window_d   = window_q;
        weights0_d = weights0_q;
        thresh0_d  = thresh0_q;
        fill_d     = flush ? '0 : fill_q;
        s0Valid_d  = 1'b0;
        if (in_valid) begin
            for (int i = N - 1; i > 0; i--) begin
                window_d[i*DATA_BITS +: DATA_BITS] = window_q[(i-1)*DATA_BITS +: DATA_BITS];
            end
            window_d[0 +: DATA_BITS] = in_data;
            if (fill_d != FILL_BITS'(N)) begin
                fill_d = fill_d + FILL_BITS'(1);
            end
            s0Valid_d  = (fill_d == FILL_BITS'(N));
            weights0_d = weights;
            thresh0_d  = thresh;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            window_q   <= '0;
            weights0_q <= '0;
            thresh0_q  <= '0;
            fill_q     <= '0;
            s0Valid_q  <= 1'b0;
        end else begin
            window_q   <= window_d;
            weights0_q <= weights0_d;
            thresh0_q  <= thresh0_d;
            fill_q     <= fill_d;
            s0Valid_q  <= s0Valid_d;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_accum
        weighted_rank_accum #(
            .N          (N),
            .DATA_BITS  (DATA_BITS),
            .WEIGHT_BITS(WEIGHT_BITS),
            .SUM_BITS   (SUM_BITS),
            .IDX_BITS   (IDX_BITS)
        ) u_accum (
            .window_i (window_q),
            .weights_i(weights0_q),
            .tapIdx_i (IDX_BITS'(i)),
            .cSum_o   (cSum[i])
        );
    end

    always_comb begin
        totalW = '0;
        for (int i = 0; i < N; i++) begin
            totalW = totalW + SUM_BITS'(weights0_q[i*WEIGHT_BITS +: WEIGHT_BITS]);
        end
    end

    // The window snapshot travels with its sums so later shifts cannot disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            vals1_q   <= '0;
            c1_q      <= '{default: '0};
            total1_q  <= '0;
            thresh1_q <= '0;
            s1Valid_q <= 1'b0;
        end else begin
            s1Valid_q <= s0Valid_q && !flush;
            if (s0Valid_q) begin
                vals1_q   <= window_q;
                c1_q      <= cSum;
                total1_q  <= totalW;
                thresh1_q <= thresh0_q;
            end
        end
    end

    always_comb begin
        minQual = '1;
        maxVal  = '0;
        for (int i = 0; i < N; i++) begin
            if ((c1_q[i] >= thresh1_q) && (vals1_q[i*DATA_BITS +: DATA_BITS] < minQual)) begin
                minQual = vals1_q[i*DATA_BITS +: DATA_BITS];
            end
            if (vals1_q[i*DATA_BITS +: DATA_BITS] > maxVal) begin
                maxVal = vals1_q[i*DATA_BITS +: DATA_BITS];
            end
        end
        selSat  = (thresh1_q > total1_q);
        selData = selSat ? maxVal : minQual;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outSat_q   <= 1'b0;
        end else begin
            outValid_q <= s1Valid_q && !flush;
            if (s1Valid_q && !flush) begin
                outData_q <= selData;
                outSat_q  <= selSat;
            end
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_sat   = outSat_q;

endmodule

// File: tb/tb_weighted_rank_order_stream.sv
// Directed bench for weighted_rank_order_stream (N=5): hand-computed windows,
// flush/reset recovery, and a throughput run checked against a sort-based model.
module tb_weighted_rank_order_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [7:0]  in_data;
    logic [14:0] weights;
    logic [5:0]  thresh;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sat;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic       s;
    } expEntry_t;

    expEntry_t  expQ[$];
    logic [7:0] mwin [5];
    logic [2:0] mwt  [5] = '{3'd1, 3'd3, 3'd0, 3'd2, 3'd1};
    int         threshTab [5] = '{3, 8, 0, 7, 5};
    bit         gapPat [10] = '{0, 1, 0, 0, 1, 1, 0, 1, 0, 0};
    int         mfill;
    int         pulses;

    weighted_rank_order_stream #(
        .N          (5),
        .DATA_BITS  (8),
        .WEIGHT_BITS(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data),
        .weights  (weights),
        .thresh   (thresh),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_sat  (out_sat)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [7:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkResult(input string tag, input logic [7:0] expData, input logic expSat);
        checkOutput({tag, ".valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, ".data"},  32'(out_data),  32'(expData));
        checkOutput({tag, ".sat"},   32'(out_sat),   32'(expSat));
    endtask

    // Feeds five samples (last one ends up in tap 0), then waits out the pipeline.
    task automatic runWindow(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input logic [7:0] d, input logic [7:0] e);
        applyStimulus(1'b1, a);
        applyStimulus(1'b1, b);
        applyStimulus(1'b1, c);
        applyStimulus(1'b1, d);
        applyStimulus(1'b1, e);
        applyStimulus(1'b0, 8'd0);
        applyStimulus(1'b0, 8'd0);
    endtask

    // Walks taps in ascending (value, index) order accumulating weight.
    function automatic void modelResult(input logic [5:0] t, output logic [7:0] d, output logic s);
        bit used [5];
        int cum;
        int best;
        bit found;
        logic [7:0] lastVal;
        cum = 0; found = 0; d = '0; s = 1'b0; lastVal = '0;
        foreach (used[k]) used[k] = 1'b0;
        for (int r = 0; r < 5; r++) begin
            best = -1;
            for (int k = 0; k < 5; k++) begin
                if (!used[k] && (best < 0 || mwin[k] < mwin[best])) best = k;
            end
            used[best] = 1'b1;
            cum += int'(mwt[best]);
            lastVal = mwin[best];
            if (!found && cum >= int'(t)) begin
                found = 1'b1;
                d = mwin[best];
            end
        end
        if (!found) begin
            d = lastVal;
            s = 1'b1;
        end
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        weights = '0; thresh = '0;
        applyStimulus(1'b0, 8'd0);
        applyStimulus(1'b0, 8'd0);
        checkOutput("reset.valid", 32'(out_valid), 32'd0);
        checkOutput("reset.data",  32'(out_data),  32'd0);
        checkOutput("reset.sat",   32'(out_sat),   32'd0);
        rst = 1'b0;

        // Median of 10,50,20,40,30
        weights = {5{3'd1}};
        thresh  = 6'd3;
        applyStimulus(1'b1, 8'd10);
        checkOutput("fill1.valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b1, 8'd50);
        checkOutput("fill2.valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b1, 8'd20);
        checkOutput("fill3.valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b1, 8'd40);
        checkOutput("fill4.valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b1, 8'd30);
        checkOutput("fill5.valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 8'd0);
        checkOutput("lat1.valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 8'd0);
        checkResult("median", 8'd30, 1'b0);
        applyStimulus(1'b0, 8'd0);
        checkOutput("pulse.valid", 32'(out_valid), 32'd0);
        checkOutput("hold.data",   32'(out_data),  32'd30);

        // Tap 0 (value 30) carries weight 3
        weights = {3'd1, 3'd1, 3'd1, 3'd1, 3'd3};
        thresh  = 6'd4;
        runWindow(8'd10, 8'd50, 8'd20, 8'd40, 8'd30);
        checkResult("weightedT4", 8'd30, 1'b0);
        thresh  = 6'd6;
        runWindow(8'd10, 8'd50, 8'd20, 8'd40, 8'd30);
        checkResult("weightedT6", 8'd40, 1'b0);

        weights = {5{3'd1}};
        thresh  = 6'd6;
        runWindow(8'd10, 8'd50, 8'd20, 8'd40, 8'd30);
        checkResult("satT6", 8'd50, 1'b1);
        thresh  = 6'd5;
        runWindow(8'd10, 8'd50, 8'd20, 8'd40, 8'd30);
        checkResult("edgeTeqW", 8'd50, 1'b0);
        thresh  = 6'd0;
        runWindow(8'd10, 8'd50, 8'd20, 8'd40, 8'd30);
        checkResult("zeroT", 8'd10, 1'b0);
        weights = '0;
        thresh  = 6'd1;
        runWindow(8'd10, 8'd50, 8'd20, 8'd40, 8'd30);
        checkResult("zeroWsat", 8'd50, 1'b1);
        thresh  = 6'd0;
        runWindow(8'd10, 8'd50, 8'd20, 8'd40, 8'd30);
        checkResult("zeroWzeroT", 8'd10, 1'b0);

        // Ties: window 7,7,7,3,3
        weights = {5{3'd1}};
        thresh  = 6'd3;
        runWindow(8'd3, 8'd3, 8'd7, 8'd7, 8'd7);
        checkResult("tieT3", 8'd7, 1'b0);
        thresh  = 6'd2;
        runWindow(8'd3, 8'd3, 8'd7, 8'd7, 8'd7);
        checkResult("tieT2", 8'd3, 1'b0);

        // Flush while streaming
        thresh = 6'd3;
        applyStimulus(1'b1, 8'd100);
        applyStimulus(1'b1, 8'd101);
        applyStimulus(1'b1, 8'd102);
        checkResult("stream100", 8'd7, 1'b0);
        applyStimulus(1'b1, 8'd103);
        applyStimulus(1'b1, 8'd104);
        checkResult("stream102", 8'd100, 1'b0);
        flush = 1'b1;
        applyStimulus(1'b1, 8'd105);
        flush = 1'b0;
        checkOutput("flushDrop1.valid", 32'(out_valid), 32'd0);
        checkOutput("flushHold.data",   32'(out_data),  32'd100);
        applyStimulus(1'b1, 8'd106);
        checkOutput("flushDrop2.valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b1, 8'd107);
        checkOutput("refill1.valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b1, 8'd108);
        checkOutput("refill2.valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b1, 8'd109);
        checkOutput("refill3.valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 8'd0);
        checkOutput("refill4.valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 8'd0);
        checkResult("afterFlush", 8'd107, 1'b0);

        // Reset mid-stream
        applyStimulus(1'b1, 8'd200);
        applyStimulus(1'b1, 8'd201);
        rst = 1'b1;
        applyStimulus(1'b1, 8'd202);
        rst = 1'b0;
        checkOutput("midRst.valid", 32'(out_valid), 32'd0);
        checkOutput("midRst.data",  32'(out_data),  32'd0);
        checkOutput("midRst.sat",   32'(out_sat),   32'd0);
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, 8'(k));
            checkOutput("rstRefill.valid", 32'(out_valid), 32'd0);
        end
        applyStimulus(1'b0, 8'd0);
        checkOutput("rstLat.valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 8'd0);
        checkResult("afterRst", 8'd3, 1'b0);

        // Throughput with per-sample thresh, then gaps
        flush = 1'b1;
        applyStimulus(1'b0, 8'd0);
        flush = 1'b0;
        for (int k = 0; k < 5; k++) weights[k*3 +: 3] = mwt[k];
        foreach (mwin[k]) mwin[k] = '0;
        mfill  = 0;
        pulses = 0;
        expQ.push_back('0);
        expQ.push_back('0);
        for (int step = 0; step < 30; step++) begin
            logic       v;
            logic [7:0] d;
            logic [5:0] t;
            logic [7:0] ed;
            logic       es;
            expEntry_t  e;
            v = (step < 20) ? 1'b1 : gapPat[step-20];
            d = 8'((step * 73 + 19) % 256);
            t = 6'(threshTab[step % 5]);
            thresh = t;
            e = '0;
            if (v) begin
                for (int k = 4; k > 0; k--) mwin[k] = mwin[k-1];
                mwin[0] = d;
                if (mfill < 5) mfill++;
                if (mfill == 5) begin
                    modelResult(t, ed, es);
                    e.v = 1'b1;
                    e.d = ed;
                    e.s = es;
                end
            end
            expQ.push_back(e);
            applyStimulus(v, d);
            e = expQ.pop_front();
            checkOutput("tp.valid", 32'(out_valid), 32'(e.v));
            if (e.v) begin
                checkOutput("tp.data", 32'(out_data), 32'(e.d));
                checkOutput("tp.sat",  32'(out_sat),  32'(e.s));
            end
            if (out_valid) pulses++;
        end
        checkOutput("tp.pulses", 32'(pulses), 32'd20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
